nf10_axis_len_checker: RTL and testbench

- Store-and-forward AXI4-Stream packet checker. It sits downstream of the width converter that writes byte length into tuser[C_LEN_WIDTH-1:0].
- Counts the actual bytes of each received packet and compares the count with the tuser length. Matching packets are forwarded unchanged; mismatched packets are dropped silently.
- This is the consuming end of the LEN subchannel.

---
 rtl/nf10_axis_len_checker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_nf10_axis_len_checker.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_len_checker.sv
// nf10_axis_len_checker
//
// Store-and-forward AXI4-Stream length checker. Every received packet is
// buffered whole in a data FIFO while its bytes are counted. On the last beat
// the byte count is compared with the LEN field carried in the low bits of
// the first-beat tuser, and a {good, tuser} verdict is queued in an info FIFO.
// The egress side forwards packets whose verdict is good and silently
// discards the rest.
//
// Optional feature: define NF10_LEN_CHECK_STATS_EN to add the saturating
// good_pkt_cnt / bad_pkt_cnt statistics ports.
//
// Ports:
//   axi_aclk       clock
//   reset          synchronous active-high reset
//   s_axis_*       ingress stream (tdata, tstrb, tuser, tvalid, tready, tlast)
//   m_axis_*       egress stream; tuser holds the packet's first-beat tuser
//   good_pkt_cnt   packets that passed the length check (optional)
//   bad_pkt_cnt    packets that failed the length check (optional)

module nf10_axis_len_checker #(
  parameter int C_DATA_WIDTH           = 64,
  parameter int C_USER_WIDTH           = 128,
  parameter int C_LEN_WIDTH            = 16,
  parameter int C_DATA_FIFO_DEPTH_BITS = 8,
  parameter int C_INFO_FIFO_DEPTH_BITS = 5
) (
  input  logic                      axi_aclk,
  input  logic                      reset,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_USER_WIDTH-1:0]   s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_USER_WIDTH-1:0]   m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
`ifdef NF10_LEN_CHECK_STATS_EN
  ,
  output logic [31:0]               good_pkt_cnt,
  output logic [31:0]               bad_pkt_cnt
`endif
);

  localparam int STRB_W  = C_DATA_WIDTH / 8;
  localparam int SUM_W   = C_LEN_WIDTH + 1;
  localparam int D_W     = 1 + STRB_W + C_DATA_WIDTH;
  localparam int D_PW    = C_DATA_FIFO_DEPTH_BITS;
  localparam int D_CW    = C_DATA_FIFO_DEPTH_BITS + 1;
  localparam int D_DEPTH = 1 << C_DATA_FIFO_DEPTH_BITS;
  localparam int I_W     = 1 + C_USER_WIDTH;
  localparam int I_PW    = C_INFO_FIFO_DEPTH_BITS;
  localparam int I_CW    = C_INFO_FIFO_DEPTH_BITS + 1;
  localparam int I_DEPTH = 1 << C_INFO_FIFO_DEPTH_BITS;

  typedef enum logic {WAIT_START, IN_PKT} in_state_t;
  typedef enum logic [1:0] {IDLE, FWD, DROP} eg_state_t;

  // Bytes carried by one beat: position of the highest strobe plus one.
  function automatic logic [SUM_W-1:0] beat_bytes(input logic [STRB_W-1:0] strb);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) n = SUM_W'(i + 1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Data FIFO (fall-through: head is read combinationally)
  // ---------------------------------------------------------------------
  logic [D_W-1:0]  d_mem [D_DEPTH];
  logic [D_PW-1:0] d_wr_ptr, d_rd_ptr;
  logic [D_CW-1:0] d_count;
  logic            d_wr, d_rd, d_empty, d_nearly_full;
  logic [D_W-1:0]  d_head;
  logic            d_head_last;

  // Nearly-full leaves room for exactly one maximum-size packet of
  // D_DEPTH-1 beats, which is what keeps store-and-forward deadlock-free.
  assign d_empty       = (d_count == '0);
  assign d_nearly_full = (d_count >= D_CW'(D_DEPTH - 1));
  assign d_head        = d_mem[d_rd_ptr];
  assign d_head_last   = d_head[D_W-1];

  always_ff @(posedge axi_aclk) begin
    if (d_wr) d_mem[d_wr_ptr] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      d_wr_ptr <= '0;
      d_rd_ptr <= '0;
      d_count  <= '0;
    end else begin
      if (d_wr) d_wr_ptr <= d_wr_ptr + D_PW'(1);
      if (d_rd) d_rd_ptr <= d_rd_ptr + D_PW'(1);
      d_count <= d_count + D_CW'(d_wr) - D_CW'(d_rd);
    end
  end

  // ---------------------------------------------------------------------
  // Info FIFO holding one {good, tuser} verdict per complete packet
  // ---------------------------------------------------------------------
  logic [I_W-1:0]  i_mem [I_DEPTH];
  logic [I_PW-1:0] i_wr_ptr, i_rd_ptr;
  logic [I_CW-1:0] i_count;
  logic            i_wr, i_rd, i_empty, i_nearly_full;
  logic [I_W-1:0]  i_din, i_head;

  assign i_empty       = (i_count == '0);
  assign i_nearly_full = (i_count >= I_CW'(I_DEPTH - 1));
  assign i_head        = i_mem[i_rd_ptr];

  always_ff @(posedge axi_aclk) begin
    if (i_wr) i_mem[i_wr_ptr] <= i_din;
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      i_wr_ptr <= '0;
      i_rd_ptr <= '0;
      i_count  <= '0;
    end else begin
      if (i_wr) i_wr_ptr <= i_wr_ptr + I_PW'(1);
      if (i_rd) i_rd_ptr <= i_rd_ptr + I_PW'(1);
      i_count <= i_count + I_CW'(i_wr) - I_CW'(i_rd);
    end
  end

  // ---------------------------------------------------------------------
  // Ingress: handshake, byte counting and verdict
  // ---------------------------------------------------------------------
  in_state_t               in_state, in_next;
  logic [C_LEN_WIDTH-1:0]  exp_len, cur_len;
  logic [C_USER_WIDTH-1:0] user_hold, cur_user;
  logic [SUM_W-1:0]        byte_sum, sum_next;
  logic [SUM_W:0]          sum_wide;
  logic                    accept, first_beat, pkt_good;

  assign s_axis_tready = ~reset & ~d_nearly_full & ~i_nearly_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign first_beat    = (in_state == WAIT_START);

  // On the first beat (including single-beat packets) the live tuser is the
  // packet's tuser; later beats use the copy latched on the first beat.
  assign cur_len  = first_beat ? s_axis_tuser[C_LEN_WIDTH-1:0] : exp_len;
  assign cur_user = first_beat ? s_axis_tuser : user_hold;

  // The sum saturates at all-ones, a value no LEN field can equal, so an
  // overflowed packet always fails the compare.
  always_comb begin
    sum_wide = '0;
    sum_next = beat_bytes(s_axis_tstrb);
    if (!first_beat) begin
      sum_wide = {1'b0, byte_sum} + {1'b0, beat_bytes(s_axis_tstrb)};
      sum_next = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    end
  end

  assign pkt_good = (sum_next == {1'b0, cur_len});
  assign d_wr     = accept;
  assign i_wr     = accept & s_axis_tlast;
  assign i_din    = {pkt_good, cur_user};

  always_comb begin
    in_next = in_state;
    if (accept) begin
      if (s_axis_tlast) in_next = WAIT_START;
      else              in_next = IN_PKT;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      in_state  <= WAIT_START;
      byte_sum  <= '0;
      exp_len   <= '0;
      user_hold <= '0;
    end else begin
      in_state <= in_next;
      if (accept) begin
        byte_sum <= sum_next;
        if (first_beat) begin
          exp_len   <= s_axis_tuser[C_LEN_WIDTH-1:0];
          user_hold <= s_axis_tuser;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Egress: forward or drop one whole packet per verdict
  // ---------------------------------------------------------------------
  eg_state_t eg_state, eg_next;
  logic      fwd_valid;

  always_comb begin
    eg_next   = eg_state;
    fwd_valid = 1'b0;
    d_rd      = 1'b0;
    i_rd      = 1'b0;
    case (eg_state)
      IDLE: begin
        if (!i_empty && !d_empty) eg_next = i_head[I_W-1] ? FWD : DROP;
      end
      FWD: begin
        fwd_valid = ~d_empty;
        if (fwd_valid && m_axis_tready) begin
          d_rd = 1'b1;
          if (d_head_last) begin
            i_rd    = 1'b1;
            eg_next = IDLE;
          end
        end
      end
      DROP: begin
        if (!d_empty) begin
          d_rd = 1'b1;
          if (d_head_last) begin
            i_rd    = 1'b1;
            eg_next = IDLE;
          end
        end
      end
      default: eg_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) eg_state <= IDLE;
    else       eg_state <= eg_next;
  end

  // Outputs come straight from the FIFO heads; valid is forced low during
  // the reset cycle so a discarded packet never shows on the bus.
  assign m_axis_tvalid = fwd_valid & ~reset;
  assign m_axis_tlast  = d_head_last & m_axis_tvalid;
  assign m_axis_tdata  = d_head[C_DATA_WIDTH-1:0];
  assign m_axis_tstrb  = d_head[C_DATA_WIDTH +: STRB_W];
  assign m_axis_tuser  = i_head[C_USER_WIDTH-1:0];

`ifdef NF10_LEN_CHECK_STATS_EN
  // Verdict counters, bumped when the verdict enters the info FIFO.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      good_pkt_cnt <= '0;
      bad_pkt_cnt  <= '0;
    end else if (i_wr) begin
      if (pkt_good) begin
        if (good_pkt_cnt != '1) good_pkt_cnt <= good_pkt_cnt + 32'd1;
      end else begin
        if (bad_pkt_cnt != '1) bad_pkt_cnt <= bad_pkt_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nf10_axis_len_checker.sv
// tb_nf10_axis_len_checker
//
// Directed bench for nf10_axis_len_checker. A packet-level model computes
// each packet's byte count from its strobes and, for packets whose count
// equals LEN, queues the beats expected at the egress. A monitor compares
// every egress handshake against that queue and checks that a stalled beat
// stays stable. Stats ports are checked when NF10_LEN_CHECK_STATS_EN is set.

module tb_nf10_axis_len_checker;

  logic         axi_aclk = 1'b0;
  logic         reset    = 1'b1;
  logic [63:0]  s_axis_tdata  = '0;
  logic [7:0]   s_axis_tstrb  = '0;
  logic [127:0] s_axis_tuser  = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast  = 1'b0;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
`ifdef NF10_LEN_CHECK_STATS_EN
  logic [31:0]  good_pkt_cnt;
  logic [31:0]  bad_pkt_cnt;
`endif

  nf10_axis_len_checker dut (
    .axi_aclk      (axi_aclk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef NF10_LEN_CHECK_STATS_EN
    ,
    .good_pkt_cnt  (good_pkt_cnt),
    .bad_pkt_cnt   (bad_pkt_cnt)
`endif
  );

  always #5 axi_aclk = ~axi_aclk;

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    out_beats = 0;
  int    m_good = 0;
  int    m_bad  = 0;
  logic  last_verdict = 1'b0;
  int    rdy_mode = 2;   // 0: always ready, 1: ready 30% of cycles, 2: never ready

  // Monitor state
  int           cyc = 0;
  int           last_tlast_cyc = 0;
  int           last_gap = 0;
  logic         mon_in_pkt = 1'b0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_beat;
  logic [127:0] prev_user;
  beat_t        mon_e;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec rule: a beat carries (highest set strobe index + 1) bytes.
  function automatic int model_beat_bytes(input logic [7:0] s);
    for (int k = 7; k >= 0; k--) if (s[k]) return k + 1;
    return 0;
  endfunction

  // Egress ready pattern
  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 99) < 30);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Compare process: every handshake against the model, stalls held stable.
  always @(negedge axi_aclk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      mon_in_pkt = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("hold_beat", {53'd0, m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata}, prev_beat);
        check_output("hold_user", m_axis_tuser, prev_user);
      end
      if (m_axis_tvalid && exp_q.size() == 0) begin
        check_output("unexpected_valid", m_axis_tvalid, 1'b0);
      end else if (m_axis_tvalid && m_axis_tready) begin
        mon_e = exp_q.pop_front();
        check_output("out_data", m_axis_tdata, mon_e.data);
        check_output("out_strb", m_axis_tstrb, mon_e.strb);
        check_output("out_last", m_axis_tlast, mon_e.last);
        check_output("out_user", m_axis_tuser, mon_e.user);
        out_beats++;
        if (!mon_in_pkt) last_gap = cyc - last_tlast_cyc - 1;
        mon_in_pkt = !m_axis_tlast;
        if (m_axis_tlast) last_tlast_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {53'd0, 1'b1, m_axis_tlast, m_axis_tstrb, m_axis_tdata};
      prev_user  = m_axis_tuser;
    end
  end

  // Present one beat and wait (bounded) until it is accepted.
  task automatic apply_stimulus(input logic [63:0] data, input logic [7:0] strb,
                                input logic last, input logic [127:0] user, output logic ok);
    logic acc;
    s_axis_tdata  = data;
    s_axis_tstrb  = strb;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge axi_aclk);
      acc = s_axis_tready;
      @(posedge axi_aclk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    s_axis_tvalid = 1'b0;
    if (!ok) check_output("ingress_timeout", {127'd0, ok}, 128'd1);
  endtask

  // Send a packet: body beats use body_strb, the last beat last_strb. Later
  // beats carry a different tuser so first-beat latching is exercised.
  task automatic send_packet(input int nbeats, input logic [15:0] len, input logic [7:0] body_strb,
                             input logic [7:0] last_strb, input logic [31:0] tag);
    beat_t        pkt[$];
    beat_t        b;
    int           bytes;
    logic         ok;
    logic [127:0] user;
    user  = {tag, tag ^ 32'hC0DE_0000, 48'h0, len};
    bytes = 0;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {tag, 32'(i)} ^ 64'h1234_5678_9ABC_DEF0;
      b.strb = (i == nbeats - 1) ? last_strb : body_strb;
      b.last = (i == nbeats - 1);
      b.user = user;
      apply_stimulus(b.data, b.strb, b.last, (i == 0) ? user : ~user, ok);
      if (!ok) return;
      bytes += model_beat_bytes(b.strb);
      pkt.push_back(b);
    end
    last_verdict = (bytes == int'(len));
    if (last_verdict) begin
      foreach (pkt[i]) exp_q.push_back(pkt[i]);
      m_good++;
    end else begin
      m_bad++;
    end
  endtask

  // Wait (bounded) for all expected beats, then confirm the output is idle.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge axi_aclk);
      n++;
    end
    check_output({name, "_drained"}, exp_q.size(), 0);
    repeat (5) @(posedge axi_aclk);
    #1;
    @(negedge axi_aclk);
    check_output({name, "_idle"}, m_axis_tvalid, 1'b0);
`ifdef NF10_LEN_CHECK_STATS_EN
    check_output({name, "_good_cnt"}, good_pkt_cnt, m_good);
    check_output({name, "_bad_cnt"}, bad_pkt_cnt, m_bad);
`endif
    @(posedge axi_aclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int             base;
  int             nb;
  int             sent;
  logic           stalled;
  logic           ok_b;
  logic [7:0]     tail_strb [7] = '{8'hFF, 8'h01, 8'h03, 8'h0F, 8'h7F, 8'h80, 8'h3C};
  int             tail_bytes [7] = '{8, 1, 2, 4, 7, 8, 6};

  initial begin
    // Reset state
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    check_output("rst_s_tready", s_axis_tready, 1'b0);
    check_output("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_output("rst_m_tlast", m_axis_tlast, 1'b0);
`ifdef NF10_LEN_CHECK_STATS_EN
    check_output("rst_good_cnt", good_pkt_cnt, 0);
    check_output("rst_bad_cnt", bad_pkt_cnt, 0);
`endif
    @(posedge axi_aclk);
    #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge axi_aclk);
    check_output("post_rst_s_tready", s_axis_tready, 1'b1);
    @(posedge axi_aclk);
    #1;

    // Model pins
    check_output("model_len20", model_beat_bytes(8'hFF) * 2 + model_beat_bytes(8'h0F), 20);
    check_output("model_strb81", model_beat_bytes(8'h81), 8);

    // LEN=20, strobes FF FF 0F: good, two-cycle latency
    base = out_beats;
    send_packet(3, 16'd20, 8'hFF, 8'h0F, 32'hA000_0001);
    check_output("good20_verdict", last_verdict, 1'b1);
    @(negedge axi_aclk);
    check_output("latency_c1", m_axis_tvalid, 1'b0);
    @(negedge axi_aclk);
    check_output("latency_c2", m_axis_tvalid, 1'b1);
    @(posedge axi_aclk);
    #1;
    drain("good20");
    check_output("good20_beats", out_beats - base, 3);

    // LEN=24 with 20 actual bytes: dropped
    base = out_beats;
    send_packet(3, 16'd24, 8'hFF, 8'h0F, 32'hA000_0002);
    check_output("bad24_verdict", last_verdict, 1'b0);
    drain("bad24");
    check_output("bad24_beats", out_beats - base, 0);

    // Good 8B, bad, good 64B buffered then released back-to-back
    rdy_mode = 2;
    base = out_beats;
    send_packet(1, 16'd8,  8'hFF, 8'hFF, 32'hB000_0001);
    send_packet(1, 16'd9,  8'hFF, 8'hFF, 32'hB000_0002);
    send_packet(8, 16'd64, 8'hFF, 8'hFF, 32'hB000_0003);
    repeat (5) @(posedge axi_aclk);
    #1;
    rdy_mode = 0;
    drain("b2b");
    check_output("b2b_beats", out_beats - base, 9);
    check_output("b2b_gap_le3", last_gap <= 3, 1'b1);

    // Two good packets buffered: at most one idle cycle between them
    rdy_mode = 2;
    send_packet(2, 16'd12, 8'hFF, 8'h08, 32'hB100_0001);
    send_packet(2, 16'd9,  8'hFF, 8'h01, 32'hB100_0002);
    repeat (5) @(posedge axi_aclk);
    #1;
    rdy_mode = 0;
    drain("good_pair");
    check_output("good_pair_gap_le1", last_gap <= 1, 1'b1);

    // LEN=0 with all-zero strobes; non-contiguous strobe 81 counts 8 bytes
    base = out_beats;
    send_packet(2, 16'd0, 8'h00, 8'h00, 32'hC000_0001);
    send_packet(1, 16'd8, 8'h81, 8'h81, 32'hC000_0002);
    drain("zero_len");
    check_output("zero_len_beats", out_beats - base, 3);

    // 40 good packets with egress ready 30% of cycles
    rdy_mode = 1;
    base = out_beats;
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      nb = 1 + (i % 6);
      send_packet(nb, 16'((nb - 1) * 8 + tail_bytes[i % 7]), 8'hFF, tail_strb[i % 7], 32'hD000_0000 + 32'(i));
      sent += nb;
    end
    drain("random_rdy");
    check_output("random_rdy_beats", out_beats - base, sent);
    rdy_mode = 0;

    // Fill with egress stalled until ingress back-pressures, then release
    rdy_mode = 2;
    repeat (2) @(posedge axi_aclk);
    #1;
    base = out_beats;
    stalled = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge axi_aclk);
      if (!s_axis_tready) begin
        stalled = 1'b1;
        break;
      end
      @(posedge axi_aclk);
      #1;
      send_packet(4, 16'd29, 8'hFF, 8'h1F, 32'hE000_0000 + 32'(i));
    end
    check_output("fill_stalled", stalled, 1'b1);
    @(posedge axi_aclk);
    #1;
    fork
      send_packet(4, 16'd29, 8'hFF, 8'h1F, 32'hE100_0000);
      begin
        repeat (30) @(posedge axi_aclk);
        #1;
        rdy_mode = 0;
      end
    join
    drain("fill");

    // Reset while a packet is stalled at the egress and another is partial
    rdy_mode = 2;
    repeat (2) @(posedge axi_aclk);
    #1;
    send_packet(2, 16'd16, 8'hFF, 8'hFF, 32'hF000_0001);
    repeat (3) @(posedge axi_aclk);
    #1;
    @(negedge axi_aclk);
    check_output("pre_rst_valid", m_axis_tvalid, 1'b1);
    @(posedge axi_aclk);
    #1;
    apply_stimulus(64'h5555_AAAA_0000_0001, 8'hFF, 1'b0, 128'd24, ok_b);
    reset = 1'b1;
    @(negedge axi_aclk);
    check_output("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    check_output("midrst_s_tready", s_axis_tready, 1'b0);
    @(posedge axi_aclk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_good = 0;
    m_bad  = 0;
    @(negedge axi_aclk);
    check_output("after_rst_m_tvalid", m_axis_tvalid, 1'b0);
    @(posedge axi_aclk);
    #1;
    rdy_mode = 0;
    base = out_beats;
    send_packet(1, 16'd8, 8'hFF, 8'hFF, 32'hF000_0002);
    drain("after_rst");
    check_output("after_rst_beats", out_beats - base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
